upcounter_ctrl: RTL and testbench
=================================

Name: upcounter_ctrl

Overview:
- Modulo-N up counter with enable, synchronous load, terminal-count flag and a one-shot run mode under a small FSM.
- Counts in the opposite direction to the team's existing down counter; uses the same clk/reset/counter interface style.
- Feeds timing/sequencing logic that needs either a free-running wrap tick or a single bounded count with a done pulse.

Parameters:
WIDTH, 4, bit width of counter; must satisfy 2**WIDTH >= MODULUS
MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  count enable, sampled each rising edge
mode  input  1  0 = free-run (wrap), 1 = one-shot; sampled only when start is accepted
start  input  1  begin one-shot run; honoured only in IDLE with mode=1
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
counter  output  WIDTH  current count (registered)
tc  output  1  high while counter == MODULUS-1 (decoded from register, no added latency)
wrap  output  1  one-cycle registered pulse, coincident with counter returning MODULUS-1 -> 0 in free-run
busy  output  1  high in RUN
done  output  1  one-cycle registered pulse on the cycle the FSM is in DONE

Behaviour:
- Reset (async assert, any time, including mid-run): counter=0, tc=0, wrap=0, busy=0, done=0, state=IDLE, mode_q=0. All outputs hold those values while reset is high.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start && mode. Counter cleared to 0 on the same edge. mode_q=1. busy=1 from the next cycle.
  - RUN -> DONE on en && counter==MODULUS-1. Counter holds MODULUS-1. busy drops and done=1 for that one cycle.
  - DONE -> IDLE unconditionally on the next edge. Counter keeps MODULUS-1 until it is loaded, restarted or counted.
- Per-edge priority: load > start > count.
  - load: counter <= load_val. If load_val >= MODULUS, counter <= MODULUS-1 (clamp). FSM state is unchanged, so a load in RUN keeps running from the loaded value.
  - start in RUN or DONE: ignored. start with mode=0: ignored; the block stays in IDLE.
  - start and load together in IDLE: load wins, start is dropped.
- Counting:
  - Free-run (IDLE, mode=0): en increments the counter. At MODULUS-1, en returns it to 0 with wrap=1 on that cycle.
  - One-shot: counting happens only in RUN. In IDLE, a counter value left over from a one-shot does not count while mode=1.
  - en=0: counter holds, wrap=0.
- mode changes during RUN have no effect; mode_q is latched at start.
- Arithmetic is unsigned, WIDTH bits. Next value is computed as (counter==MODULUS-1) ? 0 : counter+1, so there is no reliance on natural 2**WIDTH overflow.
- Latency:
  - counter, wrap and done change 1 edge after the qualifying inputs.
  - tc follows counter combinationally.

Optional Feature:
- Macro: UPCOUNTER_CTRL_SAT_EN.
- Defined:
  - In free-run, the counter saturates at MODULUS-1; further en has no effect, and wrap is tied to 0.
  - tc stays high until a load or reset.
  - One-shot behaviour is unchanged.
- Undefined: free-run wraps as described above.

Decomposition:
- Shared package upcounter_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} upc_state_t
  - localparam function for the clamp/next-value computation
- One natural sub-module: upcounter_core, holding the counter register, load clamp, increment/wrap and tc decode, with inc/load/clr inputs.
- The top-level upcounter_ctrl keeps the FSM, mode_q, and wrap/done/busy registers.

Test Plan:
1. Reset then free-run: reset=1 for 20 ns, then en=1, mode=0 for 12 cycles -> counter 0,1..9,0,1. tc=1 at 9. wrap=1 exactly on the cycle counter reads 0 after 9, and at no other time.
2. One-shot: mode=1, start pulse, en=1 -> busy=1 while counter runs 0..9. done=1 for one cycle with counter=9, busy=0 on that cycle, then IDLE. Counter stays 9 with further en.
3. Load clamp and priority: in IDLE assert load=1, load_val=13, start=1 together -> counter=9, state stays IDLE. Next cycle load_val=4 -> counter=4.
4. en gaps in RUN: start one-shot, toggle en 1,0,0,1 -> counter increments only on en cycles. start pulses during RUN and a mode flip to 0 are ignored, and done still arrives at 9.
5. Async reset mid-run: assert reset between edges while counter=6 in RUN -> counter=0, busy=0, done=0 immediately, without waiting for a clock edge. After release, the block is in IDLE.
6. With UPCOUNTER_CTRL_SAT_EN defined: free-run en=1 for 15 cycles -> counter reaches 9 and holds, tc=1 steady, wrap never asserts. A load of 2 resumes counting from 2.

Source files
------------

// File: rtl/upcounter_pkg.sv
// Shared types and helpers for the modulo-N up counter block.
package upcounter_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} upc_state_t;

    // Loaded values outside the count range are pinned to the terminal count.
    function automatic int unsigned upc_clamp(input int unsigned value, input int unsigned modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

    function automatic int unsigned upc_next(input int unsigned value, input int unsigned modulus);
        return (value == modulus - 1) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/upcounter_core.sv
// Counter register with clamped load, clear, modulo increment and terminal-count decode.
module upcounter_core
    import upcounter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Priority is load, then clear (run start), then increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (load) begin
            counter <= WIDTH'(upc_clamp(32'(load_val), MODULUS));
        end else if (clr) begin
            counter <= '0;
        end else if (inc) begin
            counter <= WIDTH'(upc_next(32'(counter), MODULUS));
        end
    end

    assign tc = (counter == MAXV);

endmodule

// File: rtl/upcounter_ctrl.sv
// Modulo-N up counter with free-run and one-shot modes under a small FSM.
// Build option UPCOUNTER_CTRL_SAT_EN makes free-run saturate at the terminal count instead of wrapping.
module upcounter_ctrl
    import upcounter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    upc_state_t state;
    logic       mode_q;
    logic       startOk;
    logic       runInc;
    logic       freeInc;

    assign startOk = (state == ST_IDLE) && start && mode && !load;
    assign runInc  = (state == ST_RUN) && mode_q && en && !tc;
`ifdef UPCOUNTER_CTRL_SAT_EN
    assign freeInc = (state == ST_IDLE) && !mode && en && !tc;
`else
    assign freeInc = (state == ST_IDLE) && !mode && en;
`endif

    upcounter_core #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .inc      (runInc | freeInc),
        .load     (load),
        .clr      (startOk),
        .load_val (load_val),
        .counter  (counter),
        .tc       (tc)
    );

    // A load on the final RUN edge keeps the run going from the loaded value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            mode_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            done <= 1'b0;
`ifdef UPCOUNTER_CTRL_SAT_EN
            wrap <= 1'b0;
`else
            wrap <= freeInc && tc && !load;
`endif
            case (state)
                ST_IDLE: begin
                    if (startOk) begin
                        state  <= ST_RUN;
                        mode_q <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (en && tc && !load) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    mode_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    mode_q <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Scoreboard bench for upcounter_ctrl: stimulus queues expected outputs, a monitor checks them.
module tb_upcounter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] counter;
    logic       tc, wrap, busy, done;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    upcounter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .start    (start),
        .load     (load),
        .load_val (load_val),
        .counter  (counter),
        .tc       (tc),
        .wrap     (wrap),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checks++;
        if (counter !== e.cnt || tc !== e.tc || wrap !== e.wrap || busy !== e.busy || done !== e.done) begin
            errors++;
            $display("[TB] FAIL %s: got cnt=%0d tc=%b wrap=%b busy=%b done=%b, want cnt=%0d tc=%b wrap=%b busy=%b done=%b",
                     e.name, counter, tc, wrap, busy, done, e.cnt, e.tc, e.wrap, e.busy, e.done);
        end
    endtask

    // Called at a falling edge: drive inputs, queue the state expected after the next rising edge.
    task automatic applyStimulus(input string name, input logic i_en, input logic i_mode, input logic i_start,
                                 input logic i_load, input logic [3:0] i_lv,
                                 input logic [3:0] e_cnt, input logic e_tc, input logic e_wrap,
                                 input logic e_busy, input logic e_done);
        exp_t e;
        en = i_en; mode = i_mode; start = i_start; load = i_load; load_val = i_lv;
        e.name = name; e.cnt = e_cnt; e.tc = e_tc; e.wrap = e_wrap; e.busy = e_busy; e.done = e_done;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: the counter presents a new output after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        exp_t e;
        logic [3:0] c;

        // Reset state while reset is held
        #12;
        e = '{"reset_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checkOutput(e);
        #8;
        reset = 1'b0;

`ifdef UPCOUNTER_CTRL_SAT_EN
        // Saturating free-run: climb to 9 and hold, never wrap
        for (int k = 1; k <= 15; k++) begin
            c = (k >= 9) ? 4'd9 : 4'(k);
            applyStimulus("sat_run", 1, 0, 0, 0, 0, c, c == 4'd9, 0, 0, 0);
        end
        applyStimulus("sat_load2", 1, 0, 0, 1, 4'd2, 4'd2, 0, 0, 0, 0);
        applyStimulus("sat_resume", 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0);
`else
        // Free-run wrap: 1..9, 0 (wrap), 1, 2
        for (int k = 1; k <= 12; k++) begin
            c = 4'(k % 10);
            applyStimulus("free_run", 1, 0, 0, 0, 0, c, c == 4'd9, k == 10, 0, 0);
        end
`endif

        // One-shot run 0..9, done pulse, then holds at 9 in IDLE
        applyStimulus("os_start", 1, 1, 1, 0, 0, 4'd0, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++)
            applyStimulus("os_count", 1, 1, 0, 0, 0, 4'(k), k == 9, 0, 1, 0);
        applyStimulus("os_done", 1, 1, 0, 0, 0, 4'd9, 1, 0, 0, 1);
        applyStimulus("os_idle", 1, 1, 0, 0, 0, 4'd9, 1, 0, 0, 0);
        applyStimulus("os_hold", 1, 1, 0, 0, 0, 4'd9, 1, 0, 0, 0);

        // Load clamp beats start; then plain load; leftover value does not count in IDLE with mode=1
        applyStimulus("load_clamp", 0, 1, 1, 1, 4'd13, 4'd9, 1, 0, 0, 0);
        applyStimulus("load_4", 0, 1, 0, 1, 4'd4, 4'd4, 0, 0, 0, 0);
        applyStimulus("idle_mode1", 1, 1, 0, 0, 0, 4'd4, 0, 0, 0, 0);

        // en gaps in RUN, stray start and a mode flip are ignored
        applyStimulus("gap_start", 0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 0);
        applyStimulus("gap_en1", 1, 1, 0, 0, 0, 4'd1, 0, 0, 1, 0);
        applyStimulus("gap_en0a", 0, 1, 1, 0, 0, 4'd1, 0, 0, 1, 0);
        applyStimulus("gap_en0b", 0, 0, 0, 0, 0, 4'd1, 0, 0, 1, 0);
        applyStimulus("gap_en1b", 1, 0, 1, 0, 0, 4'd2, 0, 0, 1, 0);
        for (int k = 3; k <= 9; k++)
            applyStimulus("gap_count", 1, 0, 0, 0, 0, 4'(k), k == 9, 0, 1, 0);
        applyStimulus("gap_done", 1, 0, 0, 0, 0, 4'd9, 1, 0, 0, 1);
        applyStimulus("gap_idle", 0, 0, 0, 0, 0, 4'd9, 1, 0, 0, 0);

        // Async reset mid-run at counter=6
        applyStimulus("rst_start", 0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++)
            applyStimulus("rst_count", 1, 1, 0, 0, 0, 4'(k), 0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        e = '{"rst_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checkOutput(e);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rst_idle", 1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        applyStimulus("rst_freerun", 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded
        en = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
